// File: rtl/processor_pkg.sv
// Shared writeback types: register index/data widths, the FIFO depth
// and the {we, rd, data} request used for buffered and registered writes.
package processor_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int COUNT_W    = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                 we;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_req_t;

    localparam wb_req_t WB_REQ_NONE = '{we: 1'b0, rd: '0, data: '0};

endpackage

// File: rtl/wb_arbiter_result_fifo2.sv
// Two-entry multdiv result buffer. Slot 0 is always the head; the raw
// slots plus a per-slot valid view are exported for the hazard compare.
module result_fifo2
    import processor_pkg::*;
(
    input  logic                           clock,
    input  logic                           ctrl_reset_n,
    input  logic                           push,
    input  wb_req_t                        push_req,
    input  logic                           pop,
    output wb_req_t                        head,
    output logic [COUNT_W-1:0]             count,
    output logic [FIFO_DEPTH-1:0]          entry_valid,
    output wb_req_t [FIFO_DEPTH-1:0]       entries
);

    wb_req_t [FIFO_DEPTH-1:0] slot;
    logic [COUNT_W-1:0]       count_q;
    logic                     do_push;
    logic                     do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && (count_q != COUNT_W'(FIFO_DEPTH));

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            slot    <= '0;
            count_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   slot[count_q[0]] <= push_req;
                2'b01: begin
                    slot[0] <= slot[1];
                    slot[1] <= WB_REQ_NONE;
                end
                // Only reachable with one entry: the new result becomes head.
                2'b11:   slot[0] <= push_req;
                default: ;
            endcase
            count_q <= count_q + COUNT_W'(do_push) - COUNT_W'(do_pop);
        end
    end

    assign head           = slot[0];
    assign count          = count_q;
    assign entries        = slot;
    assign entry_valid[0] = (count_q != '0);
    assign entry_valid[1] = (count_q == COUNT_W'(FIFO_DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: in-order pipeline results win, buffered
// multdiv results drain when the pipe is idle or after STARVE_LIMIT losses.
module wb_arbiter
    import processor_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clock,
    input  logic                 ctrl_reset_n,
    input  logic                 pipe_valid,
    input  logic [REG_IDX_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0]    pipe_data,
    output logic                 pipe_stall,
    input  logic                 md_valid,
    input  logic [REG_IDX_W-1:0] md_rd,
    input  logic [DATA_W-1:0]    md_data,
    output logic                 md_ready,
    input  logic [REG_IDX_W-1:0] query_regA,
    input  logic [REG_IDX_W-1:0] query_regB,
    output logic                 query_hit,
    output logic                 ctrl_writeEnable,
    output logic [REG_IDX_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0]    data_writeReg
);

    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    wb_req_t                  head;
    wb_req_t                  md_req;
    wb_req_t                  sel_req;
    wb_req_t                  wb_q;
    wb_req_t [FIFO_DEPTH-1:0] entries;
    logic [FIFO_DEPTH-1:0]    entry_valid;
    logic [COUNT_W-1:0]       count;
    logic [STARVE_W-1:0]      starve_cnt;
    logic [STARVE_W-1:0]      starve_next;
    logic                     fifo_busy;
    logic                     md_push;
    logic                     pop;
    logic                     pipe_win;
    logic                     hit_a;
    logic                     hit_b;

    assign fifo_busy = (count != '0);
    assign md_ready  = ctrl_reset_n && (count != COUNT_W'(FIFO_DEPTH));
    // Results for $r0 complete the handshake but never enter the buffer.
    assign md_push   = md_valid && md_ready && (md_rd != '0);
    assign md_req    = '{we: 1'b1, rd: md_rd, data: md_data};

    // Depends only on registered state so the pipeline sees it early.
    assign pipe_stall = ctrl_reset_n && fifo_busy && (starve_cnt == STARVE_MAX);

    result_fifo2 u_fifo (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .push         (md_push),
        .push_req     (md_req),
        .pop          (pop),
        .head         (head),
        .count        (count),
        .entry_valid  (entry_valid),
        .entries      (entries)
    );

    always_comb begin
        sel_req  = WB_REQ_NONE;
        pop      = 1'b0;
        pipe_win = 1'b0;
        if (pipe_stall) begin
            sel_req = head;
            pop     = 1'b1;
        end else if (pipe_valid && (pipe_rd != '0)) begin
            sel_req  = '{we: 1'b1, rd: pipe_rd, data: pipe_data};
            pipe_win = 1'b1;
        end else if (fifo_busy) begin
            sel_req = head;
            pop     = 1'b1;
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (!fifo_busy || pop) begin
            starve_next = '0;
        end else if (pipe_win && (starve_cnt != STARVE_MAX)) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            wb_q       <= WB_REQ_NONE;
            starve_cnt <= '0;
        end else begin
            wb_q       <= sel_req;
            starve_cnt <= starve_next;
        end
    end

    always_comb begin
        hit_a = wb_q.we && (wb_q.rd == query_regA);
        hit_b = wb_q.we && (wb_q.rd == query_regB);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            hit_a = hit_a || (entry_valid[i] && (entries[i].rd == query_regA));
            hit_b = hit_b || (entry_valid[i] && (entries[i].rd == query_regB));
        end
    end

    assign query_hit = ctrl_reset_n &&
                       (((query_regA != '0) && hit_a) || ((query_regB != '0) && hit_b));

    assign ctrl_writeEnable = wb_q.we;
    assign ctrl_writeReg    = wb_q.rd;
    assign data_writeReg    = wb_q.data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, pipe path, multdiv path, full FIFO,
// starvation stall, simultaneous push/pop, $r0 drop and mid-operation reset.
module tb_wb_arbiter;

    logic        clock;
    logic        ctrl_reset_n;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic [4:0]  query_regA;
    logic [4:0]  query_regB;
    logic        query_hit;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    int n_vec = 0;
    int n_err = 0;

    wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .pipe_valid       (pipe_valid),
        .pipe_rd          (pipe_rd),
        .pipe_data        (pipe_data),
        .pipe_stall       (pipe_stall),
        .md_valid         (md_valid),
        .md_rd            (md_rd),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .query_regA       (query_regA),
        .query_regB       (query_regB),
        .query_hit        (query_hit),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] data);
        check_eq({tag, ".we"},   32'(ctrl_writeEnable), 32'(we));
        check_eq({tag, ".reg"},  32'(ctrl_writeReg),    32'(rd));
        check_eq({tag, ".data"}, data_writeReg,         data);
    endtask

    // Advance past the next rising edge; inputs are changed here, away from the edge.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        pipe_valid = 1'b0;
        pipe_rd    = 5'd0;
        pipe_data  = 32'd0;
        md_valid   = 1'b0;
        md_rd      = 5'd0;
        md_data    = 32'd0;
        query_regA = 5'd0;
        query_regB = 5'd0;
    endtask

    initial begin
        // Reset with activity on every input.
        idle_inputs();
        ctrl_reset_n = 1'b0;
        md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h3333_0000;
        pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h4444_0000;
        query_regA = 5'd3; query_regB = 5'd4;
        cycle();
        check_eq("rst1.md_ready", 32'(md_ready), 32'd0);
        check_eq("rst1.stall",    32'(pipe_stall), 32'd0);
        cycle();
        check_eq("rst2.md_ready", 32'(md_ready), 32'd0);
        check_eq("rst2.stall",    32'(pipe_stall), 32'd0);
        check_eq("rst2.hit",      32'(query_hit), 32'd0);
        check_wb("rst2", 1'b0, 5'd0, 32'd0);
        ctrl_reset_n = 1'b1;
        idle_inputs();
        settle();
        check_eq("post_rst.md_ready", 32'(md_ready), 32'd1);

        // Pipe only, then a pipe result to $r0.
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEAD_BEEF;
        cycle();
        pipe_rd = 5'd0; pipe_data = 32'h0000_0001;
        settle();
        check_wb("pipe5", 1'b1, 5'd5, 32'hDEAD_BEEF);
        cycle();
        idle_inputs();
        settle();
        check_wb("pipe0", 1'b0, 5'd0, 32'd0);

        // Multdiv with idle pipe; query tracks the pending write.
        md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h1234_5678; query_regA = 5'd9;
        settle();
        check_eq("md9.ready", 32'(md_ready), 32'd1);
        check_eq("md9.hit_before", 32'(query_hit), 32'd0);
        cycle();
        md_valid = 1'b0;
        settle();
        check_eq("md9.hit_fifo", 32'(query_hit), 32'd1);
        check_eq("md9.we_early", 32'(ctrl_writeEnable), 32'd0);
        cycle();
        check_wb("md9", 1'b1, 5'd9, 32'h1234_5678);
        check_eq("md9.hit_out", 32'(query_hit), 32'd1);
        cycle();
        check_eq("md9.retired.we", 32'(ctrl_writeEnable), 32'd0);
        check_eq("md9.retired.hit", 32'(query_hit), 32'd0);
        idle_inputs();

        // FIFO full behind pipe traffic; a third result is refused.
        pipe_valid = 1'b1; pipe_rd = 5'd7; pipe_data = 32'h0000_00A0;
        md_valid = 1'b1; md_rd = 5'd10; md_data = 32'h0000_AAAA;
        cycle();
        md_rd = 5'd11; md_data = 32'h0000_BBBB;
        settle();
        check_eq("full.c1.ready", 32'(md_ready), 32'd1);
        check_wb("full.c1", 1'b1, 5'd7, 32'h0000_00A0);
        cycle();
        md_rd = 5'd12; md_data = 32'h0000_CCCC;
        settle();
        check_eq("full.c2.ready", 32'(md_ready), 32'd0);
        check_eq("full.c2.stall", 32'(pipe_stall), 32'd0);
        cycle();
        pipe_valid = 1'b0; md_valid = 1'b0;
        query_regA = 5'd12; query_regB = 5'd11;
        settle();
        check_eq("full.c3.ready", 32'(md_ready), 32'd0);
        check_eq("full.c3.hit11", 32'(query_hit), 32'd1);
        query_regB = 5'd0;
        settle();
        check_eq("full.c3.hit12", 32'(query_hit), 32'd0);
        cycle();
        check_wb("full.drain10", 1'b1, 5'd10, 32'h0000_AAAA);
        cycle();
        check_wb("full.drain11", 1'b1, 5'd11, 32'h0000_BBBB);
        cycle();
        check_wb("full.empty", 1'b0, 5'd0, 32'd0);
        idle_inputs();

        // Starvation: 4 pipe wins after buffering, then one stall cycle.
        pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'd100;
        md_valid = 1'b1; md_rd = 5'd20; md_data = 32'h0000_2020;
        cycle();
        md_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            pipe_rd = 5'(k + 1); pipe_data = 32'(100 + k);
            settle();
            check_eq($sformatf("starve.c%0d.stall", k), 32'(pipe_stall), 32'd0);
            check_wb($sformatf("starve.c%0d", k), 1'b1, 5'(k), 32'(99 + k));
            cycle();
        end
        pipe_rd = 5'd6; pipe_data = 32'd105;
        settle();
        check_eq("starve.c5.stall", 32'(pipe_stall), 32'd1);
        check_wb("starve.c5", 1'b1, 5'd5, 32'd104);
        cycle();
        check_eq("starve.c6.stall", 32'(pipe_stall), 32'd0);
        check_wb("starve.md", 1'b1, 5'd20, 32'h0000_2020);
        cycle();
        idle_inputs();
        settle();
        check_wb("starve.held", 1'b1, 5'd6, 32'd105);
        cycle();

        // Simultaneous push and pop with one entry buffered.
        md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h0000_0033;
        cycle();
        md_rd = 5'd4; md_data = 32'h0000_0044;
        settle();
        check_eq("simul.ready", 32'(md_ready), 32'd1);
        cycle();
        md_valid = 1'b0; query_regA = 5'd4;
        settle();
        check_wb("simul.head", 1'b1, 5'd3, 32'h0000_0033);
        check_eq("simul.hit4", 32'(query_hit), 32'd1);
        check_eq("simul.ready_c1", 32'(md_ready), 32'd1);
        cycle();
        check_wb("simul.next", 1'b1, 5'd4, 32'h0000_0044);
        cycle();
        check_wb("simul.empty", 1'b0, 5'd0, 32'd0);
        idle_inputs();

        // Multdiv result for $r0 is accepted but never written.
        md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h0000_00FF;
        settle();
        check_eq("md0.ready", 32'(md_ready), 32'd1);
        cycle();
        md_valid = 1'b0;
        settle();
        check_eq("md0.we1", 32'(ctrl_writeEnable), 32'd0);
        cycle();
        check_eq("md0.we2", 32'(ctrl_writeEnable), 32'd0);

        // Reset mid-operation discards a buffered result.
        md_valid = 1'b1; md_rd = 5'd8; md_data = 32'h0000_0088;
        pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h0000_0099;
        cycle();
        idle_inputs();
        query_regA = 5'd8;
        settle();
        check_eq("mid.hit_before", 32'(query_hit), 32'd1);
        ctrl_reset_n = 1'b0;
        settle();
        check_eq("mid.rst.hit", 32'(query_hit), 32'd0);
        check_eq("mid.rst.ready", 32'(md_ready), 32'd0);
        cycle();
        ctrl_reset_n = 1'b1;
        settle();
        check_eq("mid.after.hit", 32'(query_hit), 32'd0);
        check_eq("mid.after.ready", 32'(md_ready), 32'd1);
        check_wb("mid.after", 1'b0, 5'd0, 32'd0);
        cycle();
        check_eq("mid.after2.we", 32'(ctrl_writeEnable), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the memory/writeback pipeline register, the multicycle multdiv unit and the single write port of the register file. Buffers multdiv results in a 2-entry FIFO, prioritises in-order pipeline results, prevents multdiv starvation by stalling the pipeline, and drops writes to $r0. Drives the register file write port from output registers, and gives the hazard unit a pending-write query.

## Interface
- STARVE_LIMIT, 4: consecutive cycles a buffered multdiv result may lose arbitration before the pipeline is stalled.
- FIFO_DEPTH, 2: multdiv result buffer depth; fixed at 2.

- clock  in  1  single clock, rising edge.
- ctrl_reset_n  in  1  reset, synchronous, active-low.
- pipe_valid  in  1  pipeline result present this cycle.
- pipe_rd  in  5  pipeline destination register.
- pipe_data  in  32  pipeline result.
- pipe_stall  out  1  pipeline result not consumed this cycle; pipeline holds its inputs.
- md_valid  in  1  multdiv result offered.
- md_rd  in  5  multdiv destination register.
- md_data  in  32  multdiv result.
- md_ready  out  1  FIFO can accept; transfer when md_valid && md_ready.
- query_regA, query_regB  in  5 each  decode-stage source registers.
- query_hit  out  1  a pending write targets a nonzero query register.
- ctrl_writeEnable  out  1  register file write enable.
- ctrl_writeReg  out  5  register file write index.
- data_writeReg  out  32  register file write data.

## Operation
- Multdiv handshake: md_ready = (count != 2) && ctrl_reset_n.
  - An accepted entry with md_rd == 0 is consumed and discarded. It is not enqueued.
  - md_ready does not use same-cycle pop: a full FIFO refuses input even when popping.
- Arbitration each cycle. Head = oldest FIFO entry.
  - If starve_cnt == STARVE_LIMIT and FIFO is non-empty: select head, pop, assert pipe_stall.
  - Else if pipe_valid && pipe_rd != 0: select pipe.
  - Else if pipe_valid && pipe_rd == 0: consume, write nothing. If FIFO is non-empty, select head and pop.
  - Else if FIFO is non-empty: select head and pop.
  - Else: no write.
- Output registers load the selected {1, rd, data}, or {0, 0, 0} when nothing is selected.
- starve_cnt:
  - Increments when FIFO is non-empty and the pipe wins.
  - Clears on any pop or when FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Push and pop in the same cycle are legal when count is 1. FIFO order is strict.
- query_hit is combinational. It is 1 when a nonzero query register equals:
  - rd of any valid FIFO entry, or
  - ctrl_writeReg while ctrl_writeEnable = 1.
- Ordering of pipe and multdiv writes to the same rd is enforced upstream using query_hit. The arbiter does not reorder.

## Timing
- Reset, clocked while ctrl_reset_n = 0: ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0, FIFO empty, starve_cnt = 0.
  - While ctrl_reset_n = 0: pipe_stall = 0, md_ready = 0, query_hit = 0.
  - Reset mid-operation discards buffered results.
- Pipe latency: result presented in cycle N → write outputs valid in N+1 → register file written at end of N+1.
- Multdiv latency: accepted at edge E → earliest write outputs valid at E+1 edge, if the pipe is idle.
- Worst-case multdiv wait behind continuous pipe traffic: STARVE_LIMIT cycles, then one stall cycle.
- pipe_stall is combinational from registered state only: starve_cnt and count. It is never high for more than one consecutive cycle per head entry.

## Structure
- Shared package processor_pkg:
  - REG_IDX_W = 5, DATA_W = 32.
  - Constant FIFO_DEPTH = 2.
  - Struct/typedef wb_req_t {we, rd, data}, used for the FIFO entries and the output register.
- Sub-module result_fifo2: 2-entry FIFO with push, pop, count, and an entries-valid view for the query compare.
- The top level holds the arbitration logic, starve_cnt, the output register and the query comparators.

## Test plan
- Reset: hold ctrl_reset_n = 0 for 2 cycles with md_valid = 1 → md_ready = 0, ctrl_writeEnable = 0, all outputs 0.
- Pipe only: pipe rd 5 / 0xDEADBEEF, then rd 0 / 0x1 → next cycle we = 1, reg 5, 0xDEADBEEF; following cycle we = 0.
- Multdiv with idle pipe: md rd 9 / 0x12345678 accepted at edge E → ctrl_writeEnable = 1, reg 9 after edge E+1; query_regA = 9 gives query_hit = 1 from E until the write retires.
- FIFO full: push two md results with pipe_valid held high → md_ready = 0 with count 2; a third md_valid is not accepted.
- Starvation: one buffered md result plus continuous pipe_valid → exactly 4 pipe writes, then pipe_stall = 1 for one cycle while the md result is written, then the held pipe result is written.
- Simultaneous: count 1, pipe idle, md push in the same cycle → head written, new entry retained, count stays 1, order preserved.
